pj_fe_be_queue: RTL and testbench

PJ_FE_BE_QUEUE -- requirements
Module: pj_fe_be_queue

---
 rtl/pj_fe_be_queue_if.sv | 24 ++
 rtl/pj_fe_be_queue.sv | 100 ++++++++++
 tb/tb_pj_fe_be_queue.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pj_fe_be_queue_if.sv
// Front-end to back-end queue handshake: multi-lane enqueue and oldest-first dequeue.
// Suffixes are from the queue's point of view; slave is the queue side.
interface pj_fe_be_queue_if #(
   parameter int unsigned WIDTH_P     = 32,
   parameter int unsigned ENQ_LANES_P = 2,
   parameter int unsigned DEQ_LANES_P = 2
);
   logic [ENQ_LANES_P-1:0]           enq_v_i;
   logic [ENQ_LANES_P*WIDTH_P-1:0]   enq_data_i;
   logic                             enq_ready_o;
   logic [DEQ_LANES_P-1:0]           deq_v_o;
   logic [DEQ_LANES_P*WIDTH_P-1:0]   deq_data_o;
   logic [$clog2(DEQ_LANES_P+1)-1:0] deq_cnt_i;

   modport master (
      output enq_v_i, enq_data_i, deq_cnt_i,
      input  enq_ready_o, deq_v_o, deq_data_o
   );

   modport slave (
      input  enq_v_i, enq_data_i, deq_cnt_i,
      output enq_ready_o, deq_v_o, deq_data_o
   );
endinterface

// File: rtl/pj_fe_be_queue.sv
// Multi-lane circular queue between fetch and decode/issue, with flush and a sticky
// protocol-error flag. Storage is unreset; only pointers, count and error are reset.
module pj_fe_be_queue #(
   parameter int unsigned WIDTH_P     = 32,
   parameter int unsigned ELS_P       = 32,
   parameter int unsigned ENQ_LANES_P = 2,
   parameter int unsigned DEQ_LANES_P = 2,
   parameter int unsigned AFULL_P     = ELS_P - 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   pj_fe_be_queue_if.slave            q_if,
   output logic [$clog2(ELS_P+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       almost_full_o,
   output logic                       err_o
);
   localparam int unsigned PtrW    = $clog2(ELS_P);
   localparam int unsigned CntW    = $clog2(ELS_P+1);
   localparam int unsigned EnqCntW = $clog2(ENQ_LANES_P+1);
   localparam int unsigned DeqCntW = $clog2(DEQ_LANES_P+1);

   logic [WIDTH_P-1:0] r_mem [ELS_P];
   logic [PtrW-1:0]    r_rptr, r_wptr;
   logic [CntW-1:0]    r_count;
   logic               r_err;

   logic [EnqCntW-1:0]     w_enq_k;
   logic [ENQ_LANES_P-1:0] w_enq_v_inc;
   logic                   w_thermo, w_enq_any, w_ready, w_enq_fire, w_enq_err;
   logic [DeqCntW-1:0]     w_deq_avail;
   logic                   w_deq_ok, w_deq_err;
   logic [CntW-1:0]        w_enq_n, w_deq_n;

   always_comb begin
      w_enq_k = '0;
      for (int i = 0; i < int'(ENQ_LANES_P); i++) begin
         w_enq_k = w_enq_k + EnqCntW'(q_if.enq_v_i[i]);
      end
      // Thermometer code: adding one carries through the contiguous low ones only
      w_enq_v_inc = q_if.enq_v_i + ENQ_LANES_P'(1);
      w_thermo    = (q_if.enq_v_i & w_enq_v_inc) == '0;
      w_enq_any   = |q_if.enq_v_i;
      w_ready     = r_count <= CntW'(ELS_P - ENQ_LANES_P);
      w_enq_fire  = !flush_i && w_enq_any && w_thermo && w_ready;
      w_enq_err   = !flush_i && w_enq_any && !(w_thermo && w_ready);

      if (r_count >= CntW'(DEQ_LANES_P)) w_deq_avail = DeqCntW'(DEQ_LANES_P);
      else                                w_deq_avail = DeqCntW'(r_count);
      w_deq_ok  = q_if.deq_cnt_i <= w_deq_avail;
      w_deq_err = !flush_i && !w_deq_ok;

      w_enq_n = w_enq_fire ? CntW'(w_enq_k) : '0;
      w_deq_n = (!flush_i && w_deq_ok) ? CntW'(q_if.deq_cnt_i) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (flush_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         r_rptr  <= r_rptr + PtrW'(w_deq_n);
         r_wptr  <= r_wptr + PtrW'(w_enq_n);
         r_count <= r_count + w_enq_n - w_deq_n;
         if (w_enq_err || w_deq_err) r_err <= 1'b1;
      end
   end

   // Reset is excluded so stale storage is never used after reset: count gates visibility
   always_ff @(posedge clk_i) begin
      if (!reset_i && w_enq_fire) begin
         for (int i = 0; i < int'(ENQ_LANES_P); i++) begin
            if (q_if.enq_v_i[i]) begin
               r_mem[r_wptr + PtrW'(i)] <= q_if.enq_data_i[i*WIDTH_P +: WIDTH_P];
            end
         end
      end
   end

   always_comb begin
      q_if.deq_v_o    = '0;
      q_if.deq_data_o = '0;
      for (int i = 0; i < int'(DEQ_LANES_P); i++) begin
         q_if.deq_v_o[i]                       = r_count > CntW'(i);
         q_if.deq_data_o[i*WIDTH_P +: WIDTH_P] = r_mem[r_rptr + PtrW'(i)];
      end
      q_if.enq_ready_o = w_ready;
      count_o          = r_count;
      empty_o          = r_count == '0;
      almost_full_o    = r_count >= CntW'(AFULL_P);
      err_o            = r_err;
   end
endmodule

// File: tb/tb_pj_fe_be_queue.sv
// Directed and randomized checks of pj_fe_be_queue against a queue-based reference model.
module tb_pj_fe_be_queue;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset, flush;
   logic [5:0] count;
   logic empty, afull, err;

   pj_fe_be_queue_if #(.WIDTH_P(W), .ENQ_LANES_P(2), .DEQ_LANES_P(2)) q_if ();

   pj_fe_be_queue #(.WIDTH_P(W), .ELS_P(32), .ENQ_LANES_P(2), .DEQ_LANES_P(2), .AFULL_P(28)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .flush_i       (flush),
      .q_if          (q_if),
      .count_o       (count),
      .empty_o       (empty),
      .almost_full_o (afull),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;
   logic [W-1:0] mq[$];
   bit merr = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] ev, input logic [1:0] dc, input bit fl, input bit rs);
      q_if.enq_v_i    = ev;
      q_if.deq_cnt_i  = dc;
      q_if.enq_data_i = {$urandom(), $urandom()};
      flush = fl;
      reset = rs;
   endtask

   // Reference: apply one cycle of the queue rules to the model from the current inputs
   task automatic model_step();
      int k, avail;
      bit enq_ok;
      if (reset) begin
         mq.delete();
         merr = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         k = 0;
         while (k < 2 && q_if.enq_v_i[k]) k++;
         enq_ok = (k > 0) && ((q_if.enq_v_i >> k) == 0) && ((32 - mq.size()) >= 2);
         if (q_if.enq_v_i != 0 && !enq_ok) merr = 1'b1;
         avail = (mq.size() < 2) ? mq.size() : 2;
         if (int'(q_if.deq_cnt_i) > avail) merr = 1'b1;
         else repeat (int'(q_if.deq_cnt_i)) void'(mq.pop_front());
         if (enq_ok) for (int i = 0; i < k; i++) mq.push_back(q_if.enq_data_i[i*W +: W]);
      end
   endtask

   task automatic check_all();
      int n = mq.size();
      check("count", 64'(count), 64'(n));
      check("empty", 64'(empty), 64'(n == 0));
      check("afull", 64'(afull), 64'(n >= 28));
      check("ready", 64'(q_if.enq_ready_o), 64'((32 - n) >= 2));
      check("err", 64'(err), 64'(merr));
      check("deq_v", 64'(q_if.deq_v_o), 64'({n > 1, n > 0}));
      for (int i = 0; i < 2; i++) begin
         if (i < n) check("deq_data", 64'(q_if.deq_data_o[i*W +: W]), 64'(mq[i]));
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int produced;
      drive(2'b00, 2'd0, 1'b0, 1'b1);
      cyc();
      cyc();

      // Two-lane enqueue appears on both dequeue lanes the next cycle
      drive(2'b11, 2'd0, 1'b0, 1'b0);
      q_if.enq_data_i = {32'h0000_000B, 32'h0000_000A};
      cyc();
      check("ab_lane0", 64'(q_if.deq_data_o[W-1:0]), 64'h0000_000A);
      check("ab_lane1", 64'(q_if.deq_data_o[2*W-1:W]), 64'h0000_000B);
      check("ab_count", 64'(count), 64'd2);

      // Fill to 31, then an enqueue while not ready
      drive(2'b00, 2'd0, 1'b0, 1'b1);
      cyc();
      for (int i = 0; i < 15; i++) begin
         drive(2'b11, 2'd0, 1'b0, 1'b0);
         cyc();
      end
      drive(2'b01, 2'd0, 1'b0, 1'b0);
      cyc();
      check("full_ready", 64'(q_if.enq_ready_o), 64'd0);
      drive(2'b01, 2'd0, 1'b0, 1'b0);
      cyc();
      check("full_err", 64'(err), 64'd1);
      check("full_cnt", 64'(count), 64'd31);

      // Non-thermometer enqueue, then reset clears the error
      drive(2'b00, 2'd0, 1'b0, 1'b1);
      cyc();
      drive(2'b10, 2'd0, 1'b0, 1'b0);
      cyc();
      check("nothermo_err", 64'(err), 64'd1);
      drive(2'b00, 2'd0, 1'b0, 1'b1);
      cyc();
      check("rst_err", 64'(err), 64'd0);

      // Stream 100 entries, two in and one out, wrapping the storage
      produced = 0;
      for (int c = 0; c < 400 && (produced < 100 || mq.size() != 0); c++) begin
         logic [1:0] ev;
         ev = (produced < 100 && (32 - mq.size()) >= 2) ? 2'b11 : 2'b00;
         drive(ev, (mq.size() > 0) ? 2'd1 : 2'd0, 1'b0, 1'b0);
         if (ev != 0) produced += 2;
         cyc();
         check("stream_le32", 64'(count <= 6'd32), 64'd1);
      end
      check("stream_err", 64'(err), 64'd0);

      // Flush at count 5 with an error already latched
      drive(2'b00, 2'd0, 1'b0, 1'b1);
      cyc();
      drive(2'b11, 2'd0, 1'b0, 1'b0); cyc();
      drive(2'b11, 2'd0, 1'b0, 1'b0); cyc();
      drive(2'b01, 2'd0, 1'b0, 1'b0); cyc();
      drive(2'b10, 2'd0, 1'b0, 1'b0); cyc();
      check("pre_flush_cnt", 64'(count), 64'd5);
      drive(2'b11, 2'd2, 1'b1, 1'b0);
      cyc();
      check("flush_cnt", 64'(count), 64'd0);
      check("flush_empty", 64'(empty), 64'd1);
      check("flush_err", 64'(err), 64'd1);

      // Over-dequeue, then combined enqueue and dequeue
      drive(2'b00, 2'd0, 1'b0, 1'b1);
      cyc();
      drive(2'b01, 2'd0, 1'b0, 1'b0); cyc();
      drive(2'b00, 2'd2, 1'b0, 1'b0); cyc();
      check("overdeq_cnt", 64'(count), 64'd1);
      check("overdeq_err", 64'(err), 64'd1);
      drive(2'b11, 2'd1, 1'b0, 1'b0); cyc();
      check("enqdeq_cnt", 64'(count), 64'd2);

      // Random traffic including illegal patterns, flushes and resets
      for (int c = 0; c < 600; c++) begin
         logic [1:0] ev;
         logic [1:0] dc;
         ev = 2'($urandom_range(0, 3));
         dc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) :
              2'($urandom_range(0, (mq.size() < 2) ? mq.size() : 2));
         drive(ev, dc, $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
